// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX/MEM hazard inputs, data-memory handshake, stage controls.
// Latency: pure wiring, no storage.
// Backpressure: dmem_ready acknowledges dmem_req; stage enables carry hold/advance back to the pipeline.
interface hazard_ctrl_if;
    // Decode-stage operand usage
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    // Execute-stage load destination and mispredict resolution
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        modify_pc_ex;
    // Memory-stage access and data-memory handshake
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic        dmem_ready;
    logic        dmem_req;
    // Stage-register capture enables
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    // Bubble insertion
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    // Status
    logic        mem_err;
    logic [31:0] stall_cycles;

    // Pipeline / environment side: drives hazard sources, consumes controls
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_mem_read, ex_rd, modify_pc_ex,
        output mem_read_mem, mem_write_mem, dmem_ready,
        input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush, mem_err, stall_cycles
    );

    // Hazard controller side
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_mem_read, ex_rd, modify_pc_ex,
        input  mem_read_mem, mem_write_mem, dmem_ready,
        output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_flush, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall with timeout abort, mispredict flush, load-use bubble.
// Latency: all enables/flushes/dmem_req are combinational from state and inputs; only state is registered.
// Backpressure: a pending data access without dmem_ready freezes every stage until ready or timeout.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // wait_cnt holds the number of request cycles already spent on the current
    // access; the IDLE cycle that first raised the request counts as one, so the
    // abort lands on request cycle number TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic mem_acc;
    logic in_wait;
    logic timeout_hit;
    logic dmem_req_int;
    logic mem_stall;
    logic abort;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    // Hazard terms shared by the FSM, the stage controls and the stall counter
    always_comb begin
        mem_acc      = hz.mem_read_mem | hz.mem_write_mem;
        in_wait      = (state_q == MEM_WAIT);
        // >= keeps TIMEOUT=1 from waiting forever (counter is already 1 in MEM_WAIT)
        timeout_hit  = in_wait & (wait_cnt_q >= WAIT_LAST);
        dmem_req_int = ~rst & (in_wait | mem_acc);
        mem_stall    = dmem_req_int & ~hz.dmem_ready & ~timeout_hit;
        // Ready on the last allowed cycle still completes the access normally
        abort        = ~rst & timeout_hit & ~hz.dmem_ready;
        rs1_hit      = hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd);
        rs2_hit      = hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd);
        load_use     = hz.ex_mem_read & (hz.ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    end

    // Next-state and wait counter: leave MEM_WAIT on completion or timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                wait_cnt_d = 8'd0;
                if (mem_acc && !hz.dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready || timeout_hit) begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Saturating count of cycles the pipeline was frozen by memory
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (mem_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wait_cnt_q     <= 8'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Stage controls by priority: reset, memory stall, mispredict, load-use, advance
    always_comb begin
        hz.pc_en        = 1'b0;
        hz.if_id_en     = 1'b0;
        hz.id_ex_en     = 1'b0;
        hz.ex_mem_en    = 1'b0;
        hz.mem_wb_en    = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.mem_wb_flush = 1'b0;
        if (!rst && !mem_stall) begin
            hz.pc_en        = 1'b1;
            hz.if_id_en     = 1'b1;
            hz.id_ex_en     = 1'b1;
            hz.ex_mem_en    = 1'b1;
            hz.mem_wb_en    = 1'b1;
            // An aborted access must not write back stale load data
            hz.mem_wb_flush = abort;
            if (hz.modify_pc_ex) begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (load_use) begin
                // Hold IF/ID and PC, push a bubble into EX for one cycle
                hz.pc_en       = 1'b0;
                hz.if_id_en    = 1'b0;
                hz.id_ex_flush = 1'b1;
            end
        end
    end

    assign hz.dmem_req     = dmem_req_int;
    assign hz.mem_err      = abort;
    assign hz.stall_cycles = stall_cycles_q;

    // A timeout abort always discards the MEM/WB result
    a_err_flush: assert property (@(posedge clk) disable iff (rst)
        hz.mem_err |-> hz.mem_wb_flush);

    // A frozen pipeline never inserts bubbles
    a_stall_no_flush: assert property (@(posedge clk) disable iff (rst)
        !hz.pc_en && !hz.ex_mem_en |-> !hz.if_id_flush && !hz.id_ex_flush && !hz.mem_wb_flush);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (TIMEOUT=4): directed table, multi-cycle sequences, random vs model.
// Latency: outputs compared mid-cycle on the falling edge, inputs changed 1 time unit after the rising edge.
// Backpressure: dmem_ready driven directly by the bench to create waits and timeouts.
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_if hzif ();

    hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hzif.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       ld;
        logic [4:0] ex_rd;
        logic       mpc;
        logic       mrd;
        logic       mwr;
        logic       rdy;
    } in_t;

    // Output vector: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes, dmem_req, mem_err}
    typedef struct {
        in_t         i;
        logic [9:0]  e;
        string       nm;
    } vec_t;

    int errs   = 0;
    int checks = 0;

    // Reference model: index of request cycles completed in the outstanding access
    int      m_done  = 0;
    longint  m_stall = 0;

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic ld,
                               input logic [4:0] rd, input logic mpc,
                               input logic mrd, input logic mwr, input logic rdy);
        in_t r;
        r.rs1 = rs1; r.rs2 = rs2; r.use1 = u1; r.use2 = u2; r.ld = ld;
        r.ex_rd = rd; r.mpc = mpc; r.mrd = mrd; r.mwr = mwr; r.rdy = rdy;
        return r;
    endfunction

    function automatic logic [9:0] get_outs();
        return {hzif.pc_en, hzif.if_id_en, hzif.id_ex_en, hzif.ex_mem_en, hzif.mem_wb_en,
                hzif.if_id_flush, hzif.id_ex_flush, hzif.mem_wb_flush, hzif.dmem_req, hzif.mem_err};
    endfunction

    // Model: request cycle n of an access aborts when n reaches TO without ready
    function automatic void model(input in_t i, input int done,
                                  output logic [9:0] o, output bit stall, output int nxt);
        bit         req, waiting, abort, lu;
        int         n;
        logic [4:0] en;
        logic [2:0] fl;
        waiting = (done > 0);
        req     = waiting || i.mrd || i.mwr;
        n       = waiting ? done + 1 : 1;
        abort   = req && !i.rdy && waiting && (n >= TO);
        stall   = req && !i.rdy && !abort;
        lu      = i.ld && (i.ex_rd != 0) &&
                  ((i.use1 && i.rs1 == i.ex_rd) || (i.use2 && i.rs2 == i.ex_rd));
        en = 5'b11111;
        fl = 3'b000;
        if (stall) begin
            en = 5'b00000;
        end else begin
            fl[0] = abort;
            if (i.mpc) begin
                fl[2:1] = 2'b11;
            end else if (lu) begin
                en[4:3] = 2'b00;
                fl[1]   = 1'b1;
            end
        end
        o   = {en, fl, req, abort};
        nxt = stall ? n : 0;
    endfunction

    task automatic apply(input in_t i);
        hzif.id_rs1        = i.rs1;
        hzif.id_rs2        = i.rs2;
        hzif.id_use_rs1    = i.use1;
        hzif.id_use_rs2    = i.use2;
        hzif.ex_mem_read   = i.ld;
        hzif.ex_rd         = i.ex_rd;
        hzif.modify_pc_ex  = i.mpc;
        hzif.mem_read_mem  = i.mrd;
        hzif.mem_write_mem = i.mwr;
        hzif.dmem_ready    = i.rdy;
    endtask

    task automatic check10(input logic [9:0] got, input logic [9:0] exp, input string nm);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: outs got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic check32(input logic [31:0] got, input logic [31:0] exp, input string nm);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: stall_cycles got %0d expected %0d", nm, got, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model (and an explicit value if given), advance
    task automatic step(input in_t i, input bit use_exp, input logic [9:0] exp, input string nm);
        logic [9:0] mo;
        bit         st;
        int         nxt;
        apply(i);
        @(negedge clk);
        model(i, m_done, mo, st, nxt);
        check10(get_outs(), mo, {nm, "/model"});
        if (use_exp) check10(get_outs(), exp, nm);
        check32(hzif.stall_cycles, 32'(m_stall), {nm, "/cnt"});
        @(posedge clk);
        m_done = nxt;
        if (st && m_stall != 64'hFFFF_FFFF) m_stall++;
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        #1;
        check10(get_outs(), 10'b0, {nm, "/rst_outs"});
        @(posedge clk);
        #1;
        check32(hzif.stall_cycles, 32'd0, {nm, "/rst_cnt"});
        rst = 1'b0;
        m_done  = 0;
        m_stall = 0;
    endtask

    localparam logic [9:0] RUN   = 10'b11111_000_0_0;
    localparam logic [9:0] RUNRQ = 10'b11111_000_1_0;
    localparam logic [9:0] STALL = 10'b00000_000_1_0;
    localparam logic [9:0] LU    = 10'b00111_010_0_0;
    localparam logic [9:0] MPC   = 10'b11111_110_0_0;
    localparam logic [9:0] ABORT = 10'b11111_001_1_1;

    vec_t tbl[12];
    in_t  idle_i, ld_i, ri;

    initial begin
        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RUN,   "quiet"};
        tbl[1]  = '{mk(7, 1, 1, 0, 1, 7, 0, 0, 0, 0), LU,    "lu_rs1"};
        tbl[2]  = '{mk(7, 1, 0, 0, 1, 7, 0, 0, 0, 0), RUN,   "lu_rs1_unused"};
        tbl[3]  = '{mk(2, 5, 0, 1, 1, 5, 0, 0, 0, 0), LU,    "lu_rs2"};
        tbl[4]  = '{mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0), RUN,   "lu_rd0"};
        tbl[5]  = '{mk(9, 9, 1, 1, 0, 9, 0, 0, 0, 0), RUN,   "no_load"};
        tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), MPC,   "mpc"};
        tbl[7]  = '{mk(3, 3, 1, 1, 1, 3, 1, 0, 0, 0), MPC,   "mpc_over_lu"};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), RUNRQ, "zero_wait_rd"};
        tbl[9]  = '{mk(4, 0, 1, 0, 1, 4, 0, 0, 1, 1), 10'b00111_010_1_0, "zero_wait_wr_lu"};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1), 10'b11111_110_1_0, "zero_wait_mpc"};
        tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), RUN,   "ready_no_acc"};

        idle_i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld_i   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply(idle_i);
        ld_i.mrd = 1'b1;
        do_reset("init");

        // Single-cycle cases from IDLE
        for (int n = 0; n < 12; n++) step(tbl[n].i, 1'b1, tbl[n].e, tbl[n].nm);
        check32(hzif.stall_cycles, 32'd0, "table_no_stall");

        // Load with three wait cycles
        for (int n = 0; n < 3; n++) step(ld_i, 1'b1, STALL, "ld3_wait");
        ri = ld_i; ri.rdy = 1'b1;
        step(ri, 1'b1, RUNRQ, "ld3_done");
        check32(hzif.stall_cycles, 32'd3, "ld3_cnt");
        step(idle_i, 1'b1, RUN, "ld3_idle");

        // Load-use bubble lasts one cycle once EX holds the bubble
        step(mk(0, 5, 0, 1, 1, 5, 0, 0, 0, 0), 1'b1, LU, "lu_seq");
        step(mk(0, 5, 0, 1, 0, 5, 0, 0, 0, 0), 1'b1, RUN, "lu_after");

        // Timeout: abort on request cycle TO, then back to IDLE
        do_reset("to");
        for (int n = 0; n < TO - 1; n++) step(ld_i, 1'b1, STALL, "to_wait");
        step(ld_i, 1'b1, ABORT, "to_abort");
        check32(hzif.stall_cycles, 32'd3, "to_cnt");
        step(idle_i, 1'b1, RUN, "to_idle");
        // Abort with a load-use match still bubbles EX
        for (int n = 0; n < TO - 1; n++) step(ld_i, 1'b1, STALL, "to_lu_wait");
        ri = ld_i; ri.ld = 1'b1; ri.ex_rd = 5'd6; ri.rs1 = 5'd6; ri.use1 = 1'b1;
        step(ri, 1'b1, 10'b00111_011_1_1, "to_abort_lu");
        // Ready coinciding with the last allowed cycle wins
        for (int n = 0; n < TO - 1; n++) step(ld_i, 1'b1, STALL, "to_rdy_wait");
        ri = ld_i; ri.rdy = 1'b1;
        step(ri, 1'b1, RUNRQ, "to_rdy_wins");
        step(ld_i, 1'b1, STALL, "to_rdy_reidle");
        step(ri, 1'b1, RUNRQ, "to_rdy_reidle_done");

        // Mispredict while waiting: held, then flushed on completion
        ri = ld_i; ri.mpc = 1'b1;
        step(ri, 1'b1, STALL, "mpc_wait");
        ri.rdy = 1'b1;
        step(ri, 1'b1, 10'b11111_110_1_0, "mpc_done");

        // Reset in the middle of a wait
        step(ld_i, 1'b1, STALL, "rst_wait1");
        step(ld_i, 1'b1, STALL, "rst_wait2");
        do_reset("rst_mid");
        step(idle_i, 1'b1, RUN, "rst_after_idle");
        step(ld_i, 1'b1, STALL, "rst_after_req");
        ri = ld_i; ri.rdy = 1'b1;
        step(ri, 1'b1, RUNRQ, "rst_after_done");

        // Random traffic against the model
        do_reset("rand");
        for (int n = 0; n < 3000; n++) begin
            ri.rs1   = 5'($urandom_range(0, 3));
            ri.rs2   = 5'($urandom_range(0, 3));
            ri.use1  = 1'($urandom_range(0, 1));
            ri.use2  = 1'($urandom_range(0, 1));
            ri.ld    = 1'($urandom_range(0, 1));
            ri.ex_rd = 5'($urandom_range(0, 3));
            ri.mpc   = ($urandom_range(0, 5) == 0);
            ri.mrd   = ($urandom_range(0, 3) == 0);
            ri.mwr   = ($urandom_range(0, 5) == 0);
            ri.rdy   = ($urandom_range(0, 2) == 0);
            step(ri, 1'b0, 10'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
